// File: rtl/uart_rx_frame.sv
// Asynchronous serial receiver: start/data/parity/stop framing with a ready flag and error status.
// Optional RX_GLITCH_FILTER_EN adds a 3-sample majority filter on the synchronized line.
`timescale 1ns/1ps
module uart_rx_frame #(
   parameter int CNT_W       = 19,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       eight,
   input  logic       pen,
   input  logic       ohel,
   input  logic [3:0] baud,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rxrdy,
   output logic       perr,
   output logic       ferr,
   output logic       ovf,
   output logic [2:0] fsm_state
);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t           state, state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic             rx_s, rx_f;
   logic [CNT_W-1:0] cnt, k_l, k_sel, half_m1;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             eight_l, pen_l, ohel_l, par_bit;
   logic             start_det, cnt_clr, shift_en, par_en, done;
   logic             bit_end, last_bit;

   // Line idles high, so the synchronizer resets to 1 to avoid a false start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync <= '1;
      else       sync <= {sync[SYNC_STAGES-2:0], rx};
   end
   assign rx_s = sync[SYNC_STAGES-1];

`ifdef RX_GLITCH_FILTER_EN
   logic [2:0] flt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) flt <= 3'b111;
      else       flt <= {flt[1:0], rx_s};
   end
   assign rx_f = (flt[0] & flt[1]) | (flt[1] & flt[2]) | (flt[0] & flt[2]);
`else
   assign rx_f = rx_s;
`endif

   always_comb begin
      case (baud)
         4'h0:    k_sel = CNT_W'(333333);
         4'h1:    k_sel = CNT_W'(83333);
         4'h2:    k_sel = CNT_W'(41667);
         4'h3:    k_sel = CNT_W'(20833);
         4'h4:    k_sel = CNT_W'(10417);
         4'h5:    k_sel = CNT_W'(5208);
         4'h6:    k_sel = CNT_W'(2604);
         4'h7:    k_sel = CNT_W'(1736);
         4'h8:    k_sel = CNT_W'(868);
         4'h9:    k_sel = CNT_W'(434);
         4'hA:    k_sel = CNT_W'(217);
         default: k_sel = CNT_W'(109);
      endcase
   end

   assign half_m1  = (k_l >> 1) - 1'b1;
   assign bit_end  = (cnt == k_l - 1'b1);
   assign last_bit = (bit_idx == (eight_l ? 3'd7 : 3'd6));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_det = 1'b0;
      cnt_clr   = 1'b0;
      shift_en  = 1'b0;
      par_en    = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:  if (!rx_f) begin start_det = 1'b1; state_nxt = START; end
         START: if (cnt == half_m1) begin
                   cnt_clr   = 1'b1;
                   state_nxt = rx_f ? IDLE : DATA;
                end
         DATA:  if (bit_end) begin
                   cnt_clr  = 1'b1;
                   shift_en = 1'b1;
                   if (last_bit) state_nxt = pen_l ? PAR : STOP;
                end
         PAR:   if (bit_end) begin cnt_clr = 1'b1; par_en = 1'b1; state_nxt = STOP; end
         STOP:  if (bit_end) begin cnt_clr = 1'b1; done = 1'b1; state_nxt = IDLE; end
         default: state_nxt = IDLE;
      endcase
   end

   // Frame format and bit time are frozen at start detect for the whole frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         k_l     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         eight_l <= 1'b0;
         pen_l   <= 1'b0;
         ohel_l  <= 1'b0;
         par_bit <= 1'b0;
      end else begin
         if (start_det || cnt_clr) cnt <= '0;
         else if (state != IDLE)   cnt <= cnt + 1'b1;
         if (start_det) begin
            k_l     <= k_sel;
            eight_l <= eight;
            pen_l   <= pen;
            ohel_l  <= ohel;
            bit_idx <= '0;
            shreg   <= '0;
         end
         if (shift_en) begin
            shreg   <= {rx_f, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
         end
         if (par_en) par_bit <= rx_f;
      end
   end

   // A completion coinciding with clr_rdy leaves rxrdy set and ovf clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data <= '0;
         rxrdy   <= 1'b0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
         ovf     <= 1'b0;
      end else if (done) begin
         rx_data <= eight_l ? shreg : {1'b0, shreg[7:1]};
         perr    <= pen_l & (par_bit != (^shreg ^ ohel_l));
         ferr    <= ~rx_f;
         rxrdy   <= 1'b1;
         ovf     <= clr_rdy ? 1'b0 : (ovf | rxrdy);
      end else if (clr_rdy) begin
         rxrdy <= 1'b0;
         ovf   <= 1'b0;
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed frames plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_frame;

   logic       clk = 1'b0;
   logic       reset, rx, eight, pen, ohel, clr_rdy;
   logic [3:0] baud;
   logic [7:0] rx_data;
   logic       rxrdy, perr, ferr, ovf;
   logic [2:0] fsm_state;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_d;
   logic       exp_rdy, exp_ovf, exp_perr, exp_ferr;
   time        t_start, rdy_time;

   uart_rx_frame dut (
      .clk(clk), .reset(reset), .rx(rx), .eight(eight), .pen(pen), .ohel(ohel),
      .baud(baud), .clr_rdy(clr_rdy), .rx_data(rx_data), .rxrdy(rxrdy),
      .perr(perr), .ferr(ferr), .ovf(ovf), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   always @(posedge rxrdy) rdy_time = $time;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic clr_pulse();
      @(negedge clk) clr_rdy = 1'b1;
      @(negedge clk) clr_rdy = 1'b0;
      exp_rdy = 1'b0;
      exp_ovf = 1'b0;
   endtask

   // Drives one frame at k clk cycles per bit; chg scrambles the switches after the start bit.
   task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok,
                             input int k, input bit chg);
      int         bt;
      logic       f_eight, f_pen, f_ohel, p;
      logic [3:0] f_baud;
      logic [7:0] dv;
      bt      = k * 10;
      f_eight = eight;
      f_pen   = pen;
      f_ohel  = ohel;
      f_baud  = baud;
      dv      = f_eight ? d : {1'b0, d[6:0]};
      p       = ^dv ^ f_ohel;
      if (!par_ok) p = ~p;
      @(negedge clk);
      t_start = $time;
      rx = 1'b0;
      #(bt);
      if (chg) begin
         eight = ~f_eight; pen = ~f_pen; ohel = ~f_ohel; baud = 4'd0;
      end
      for (int i = 0; i < (f_eight ? 8 : 7); i++) begin
         rx = d[i];
         #(bt);
      end
      if (f_pen) begin
         rx = p;
         #(bt);
      end
      if (stop_ok) begin
         rx = 1'b1;
         #(bt);
      end else begin
         // Release shortly after mid-bit so the trailing low cannot start a real frame.
         rx = 1'b0;
         #(bt * 6 / 10);
         rx = 1'b1;
         #(bt * 14 / 10);
      end
      if (chg) begin
         eight = f_eight; pen = f_pen; ohel = f_ohel; baud = f_baud;
      end
      // Frame-level reference model
      exp_q.push_back(dv);
      exp_perr = f_pen & !par_ok;
      exp_ferr = !stop_ok;
      exp_ovf  = exp_ovf | exp_rdy;
      exp_rdy  = 1'b1;
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      int seen;
      reset = 1'b1; rx = 1'b1; clr_rdy = 1'b0;
      eight = 1'b1; pen = 1'b0; ohel = 1'b0; baud = 4'hB;
      exp_rdy = 1'b0; exp_ovf = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0;
      #50;
      n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
      n_vec++; if ({rxrdy, perr, ferr, ovf} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", {rxrdy, perr, ferr, ovf}); end
      #50;
      @(negedge clk) reset = 1'b0;
      n_vec++; if (fsm_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
      seen = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (rxrdy !== 1'b0 || fsm_state !== 3'd0) seen++;
      end
      n_vec++; if (seen !== 0) begin n_err++; $display("FAIL idle_quiet: got %0d active cycles expected 0", seen); end
   endtask

   task automatic check_frame(input string name);
      exp_d = exp_q[$];
      exp_q.delete();
      n_vec++; if (rx_data !== exp_d) begin n_err++; $display("FAIL %s_data: got %h expected %h", name, rx_data, exp_d); end
      n_vec++; if (rxrdy !== exp_rdy) begin n_err++; $display("FAIL %s_rxrdy: got %b expected %b", name, rxrdy, exp_rdy); end
      n_vec++; if (perr !== exp_perr) begin n_err++; $display("FAIL %s_perr: got %b expected %b", name, perr, exp_perr); end
      n_vec++; if (ferr !== exp_ferr) begin n_err++; $display("FAIL %s_ferr: got %b expected %b", name, ferr, exp_ferr); end
      n_vec++; if (ovf !== exp_ovf) begin n_err++; $display("FAIL %s_ovf: got %b expected %b", name, ovf, exp_ovf); end
   endtask

   task automatic test_basic();
      time lim;
      eight = 1'b1; pen = 1'b0; baud = 4'hB;
      rdy_time = 0;
      send_frame(8'hA5, 1'b1, 1'b1, 109, 1'b0);
      check_frame("basic");
      // 9.5 bit times plus a few cycles of synchronizer and start-detect latency
      lim = (19 * 1090) / 2 + 80;
      n_vec++;
      if (rdy_time <= t_start || rdy_time - t_start > lim) begin
         n_err++; $display("FAIL basic_latency: got %0t after start expected <= %0t", rdy_time - t_start, lim);
      end
      clr_pulse();
   endtask

   task automatic test_parity();
      eight = 1'b0; pen = 1'b1; ohel = 1'b1; baud = 4'hB;
      send_frame(8'h35, 1'b1, 1'b1, 109, 1'b0);
      check_frame("par_ok");
      clr_pulse();
      send_frame(8'h35, 1'b0, 1'b1, 109, 1'b0);
      check_frame("par_bad");
      clr_pulse();
   endtask

   task automatic test_framing();
      eight = 1'b1; pen = 1'b0; ohel = 1'b0; baud = 4'hB;
      send_frame(8'h5A, 1'b1, 1'b0, 109, 1'b0);
      check_frame("ferr");
      clr_pulse();
   endtask

   task automatic test_back_to_back();
      eight = 1'b1; pen = 1'b0; baud = 4'hB;
      send_frame(8'h11, 1'b1, 1'b1, 109, 1'b0);
      send_frame(8'h22, 1'b1, 1'b1, 109, 1'b0);
      check_frame("overrun");
      clr_pulse();
      #20;
      n_vec++; if ({rxrdy, ovf} !== 2'b00) begin n_err++; $display("FAIL clr_rdy: got %b expected 00", {rxrdy, ovf}); end
      n_vec++; if (rx_data !== 8'h22) begin n_err++; $display("FAIL clr_keeps_data: got %h expected 22", rx_data); end
   endtask

   task automatic test_midframe_change();
      eight = 1'b1; pen = 1'b0; ohel = 1'b0; baud = 4'hB;
      send_frame(8'hC3, 1'b1, 1'b1, 109, 1'b1);
      check_frame("latched_cfg");
      clr_pulse();
   endtask

   task automatic test_glitch();
      logic [7:0] held;
      held = rx_data;
      @(negedge clk) rx = 1'b0;
      #200;
      n_vec++; if (fsm_state === 3'd0) begin n_err++; $display("FAIL glitch_start: got state %0d expected non-idle", fsm_state); end
      #100 rx = 1'b1;
      #1090;
      n_vec++; if (fsm_state !== 3'd0) begin n_err++; $display("FAIL glitch_idle: got state %0d expected 0", fsm_state); end
      n_vec++; if (rxrdy !== 1'b0 || rx_data !== held) begin n_err++; $display("FAIL glitch_rdy: got %b/%h expected 0/%h", rxrdy, rx_data, held); end
`ifdef RX_GLITCH_FILTER_EN
      begin
         int moved;
         moved = 0;
         @(negedge clk) rx = 1'b0;
         #10 rx = 1'b1;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fsm_state !== 3'd0) moved++;
         end
         n_vec++; if (moved !== 0) begin n_err++; $display("FAIL filter_pulse: got %0d non-idle cycles expected 0", moved); end
      end
`endif
   endtask

   task automatic test_reset_midframe();
      @(negedge clk) rx = 1'b0;
      #1090 rx = 1'b1;
      #3270;
      @(negedge clk) reset = 1'b1;
      #100;
      @(negedge clk) reset = 1'b0;
      #8720;
      n_vec++; if ({rxrdy, perr, ferr, ovf} !== 4'b0000 || rx_data !== 8'h00) begin
         n_err++; $display("FAIL reset_midframe: got %b/%h expected 0000/00", {rxrdy, perr, ferr, ovf}, rx_data);
      end
      exp_rdy = 1'b0; exp_ovf = 1'b0;
   endtask

   task automatic test_random();
      int k;
      for (int n = 0; n < 12; n++) begin
         eight = 1'($urandom_range(0, 1));
         pen   = 1'($urandom_range(0, 1));
         ohel  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin baud = 4'hA; k = 217; end
         else begin baud = 4'($urandom_range(11, 15)); k = 109; end
         clr_pulse();
         send_frame(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, k, 1'b0);
         check_frame("random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_back_to_back();
      test_midframe_change();
      test_glitch();
      test_reset_midframe();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
